// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-channel round-robin arbiter.
package arb_pkg;

    localparam int ARB_N    = 4;
    localparam int ARB_SELW = 2;
    localparam int ARB_CNTW = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/mux4.sv
// Plain 4:1 word multiplexer; the arbiter's out_sel drives sel.
module mux4 #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y
);

    // NOTE: y gets a default before the case so no latch can be inferred.
    always_comb begin
        y = d0;
        case (sel)
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]    req,
    input  logic [ARB_SELW-1:0] ptr,
    output logic                found,
    output logic [ARB_SELW-1:0] idx
);

    // Scan from the farthest offset down so the closest hit to ptr wins.
    always_comb begin
        found = |req;
        idx   = ptr;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            if (req[ptr + ARB_SELW'(k)]) begin
                idx = ptr + ARB_SELW'(k);
            end
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// Four-input round-robin arbiter with valid/ready handshakes feeding one mux4.
// Define ARB4_STATS_EN to add saturating per-channel grant counters (grant_cnt).
module arb4_rr
    import arb_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ARB_N-1:0]    req_valid,
    input  logic [DW-1:0]       d0,
    input  logic [DW-1:0]       d1,
    input  logic [DW-1:0]       d2,
    input  logic [DW-1:0]       d3,
    output logic [ARB_N-1:0]    req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [ARB_SELW-1:0] out_sel
`ifdef ARB4_STATS_EN
    ,
    output logic [ARB_N-1:0][ARB_CNTW-1:0] grant_cnt
`endif
);

    arb_state_e          state;
    logic [ARB_SELW-1:0] ptr;
    logic [ARB_SELW-1:0] pick_ptr;
    logic [ARB_SELW-1:0] pick_idx;
    logic                pick_found;
    logic                granting;
    logic                handshake;

    assign granting  = (state == ARB_GRANT);
    assign out_valid = granting && req_valid[out_sel];
    assign handshake = out_valid && out_ready;

    // On a handshake the re-pick starts just past the served channel, making it lowest priority.
    assign pick_ptr = handshake ? out_sel + ARB_SELW'(1) : ptr;

    always_comb begin
        req_ready = '0;
        if (granting) begin
            req_ready[out_sel] = out_ready;
        end
    end

    rr_pick4 u_pick (
        .req   (req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux4 #(.DW(DW)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (out_sel),
        .y   (out_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            out_sel <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        out_sel <= pick_idx;
                        state   <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (handshake) begin
                        ptr <= out_sel + ARB_SELW'(1);
                        if (pick_found) begin
                            out_sel <= pick_idx;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end else if (!req_valid[out_sel]) begin
                        // Producer withdrew before its handshake: abandon the grant, keep ptr.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB4_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (handshake && (grant_cnt[out_sel] != {ARB_CNTW{1'b1}})) begin
            grant_cnt[out_sel] <= grant_cnt[out_sel] + ARB_CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arb4_rr.sv
// Self-checking bench for arb4_rr: per-cycle model comparison plus directed literal checks.
module tb_arb4_rr;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] req_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;
`ifdef ARB4_STATS_EN
    logic [ARB_N-1:0][ARB_CNTW-1:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    arb4_rr #(.DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef ARB4_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who is granted, where the rotation stands, and how many grants each channel got.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    int m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_cnt[4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_sel  = 0;
            m_ptr  = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (m_busy == 0) begin
            if (pick(req_valid, m_ptr) >= 0) begin
                m_sel  = pick(req_valid, m_ptr);
                m_busy = 1;
            end
        end else if (req_valid[m_sel] && out_ready) begin
            if (m_cnt[m_sel] < 255) m_cnt[m_sel]++;
            m_ptr = (m_sel + 1) % 4;
            if (pick(req_valid, m_ptr) >= 0) m_sel = pick(req_valid, m_ptr);
            else m_busy = 0;
        end else if (!req_valid[m_sel]) begin
            m_busy = 0;
        end
    end

    logic [3:0] d_arr[4];

    always @(negedge clk) begin
        d_arr = '{d0, d1, d2, d3};
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_out_sel", out_sel, 0);
        end else begin
            check("m_out_valid", out_valid, (m_busy != 0) && req_valid[m_sel]);
            check("m_req_ready", req_ready, (m_busy != 0 && out_ready) ? (32'd1 << m_sel) : 32'd0);
            if (m_busy != 0) begin
                check("m_out_sel", out_sel, m_sel);
                check("m_out_data", out_data, d_arr[m_sel]);
            end
        end
`ifdef ARB4_STATS_EN
        for (int i = 0; i < 4; i++) check("m_grant_cnt", grant_cnt[i], m_cnt[i]);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] held;

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        d0 = 4'h3; d1 = 4'h5; d2 = 4'hA; d3 = 4'hC;

        // Reset with every input active, then first grant to channel 0.
        tick();
        check("reset_valid", out_valid, 0);
        check("reset_ready", req_ready, 4'b0000);
        check("reset_sel", out_sel, 0);
        check("reset_data", out_data, 4'h3);
        tick();
        rst_n = 1'b1;
        tick();
        check("first_grant_sel", out_sel, 0);
        check("first_grant_valid", out_valid, 1);

        // Single request on channel 2.
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b0100;
        tick();
        check("single_valid", out_valid, 1);
        check("single_sel", out_sel, 2);
        check("single_data", out_data, 4'hA);
        check("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        check("single_idle_valid", out_valid, 0);
        check("single_idle_ready", req_ready, 4'b0000);
        req_valid = 4'b1111;
        tick();
        check("ptr_after_ch2_sel", out_sel, 3);

        // All four requesting: 0,1,2,3,0,1.
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_sel", out_sel, i % 4);
            check("rr_valid", out_valid, 1);
        end

        // Backpressure on channel 1 while channel 0 starts requesting.
        req_valid = 4'b0000;
        do_reset();
        out_ready = 1'b0;
        req_valid = 4'b0010;
        tick();
        check("bp_sel", out_sel, 1);
        held = out_data;
        check("bp_data", held, 4'h5);
        req_valid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_sel", out_sel, 1);
            check("bp_hold_data", out_data, 4'h5);
            check("bp_hold_ready", req_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", req_ready, 4'b0010);
        tick();
        check("bp_next_sel", out_sel, 0);

        // Asynchronous reset in the middle of a grant.
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b1111;
        tick();
        tick();
        check("pre_async_sel", out_sel, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_ready", req_ready, 4'b0000);
        check("async_sel", out_sel, 0);
        check("async_data", out_data, 4'h3);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_async_sel", out_sel, 0);

`ifdef ARB4_STATS_EN
        // Saturation: 300+ handshakes on channel 3 only.
        req_valid = 4'b0000;
        do_reset();
        req_valid = 4'b1000;
        out_ready = 1'b1;
        repeat (302) tick();
        check("cnt3_sat", grant_cnt[3], 255);
        check("cnt0_zero", grant_cnt[0], 0);
        check("cnt1_zero", grant_cnt[1], 0);
        check("cnt2_zero", grant_cnt[2], 0);
`endif

        req_valid = 4'b0000;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-input round-robin arbiter with a valid/ready handshake on every channel. It sits directly upstream of the 4:1 data multiplexer: it owns the 2-bit select, holds it stable for the whole of a transfer, and drives the selected 4-bit word downstream through a `mux4` instance. It replaces static select wiring wherever four producers share one 4-bit consumer.

## Interface
Parameters:
- `DW`, default 4: data width per channel. Must match the `mux4` data width.

Ports (clock and reset first):
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, **asynchronous assert, active-low**.
- `req_valid` input, 4 bits: per-channel request. Bit i belongs to channel i.
- `d0`, `d1`, `d2`, `d3` input, DW bits each: per-channel data.
- `req_ready` output, 4 bits: per-channel acceptance. At most one bit is high.
- `out_valid` output, 1 bit: the downstream word is valid.
- `out_ready` input, 1 bit: the downstream consumer accepts the word.
- `out_data` output, DW bits: the selected channel's data.
- `out_sel` output, 2 bits: the current grant index, also the mux select.
- `grant_cnt` output, 4×8 bits: per-channel grant counters. Present only with `ARB4_STATS_EN`.

## Operation
- Two-state FSM:
  - IDLE: nothing granted.
  - GRANT: `out_sel` is held.
- Round-robin pointer `ptr` (2 bits):
  - The picker grants the first set bit of `req_valid`, scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- IDLE:
  - If any `req_valid` bit is set: `out_sel` takes the pick and the FSM moves to GRANT.
  - Otherwise it stays in IDLE.
- GRANT, combinational outputs:
  - `out_valid = req_valid[out_sel]`.
  - `out_data = d[out_sel]`.
  - `req_ready[out_sel] = out_ready`; all other `req_ready` bits are 0.
- Handshake is `out_valid && out_ready`. On a handshake:
  - `ptr` takes `out_sel+1` (mod 4; 3 wraps to 0).
  - The next pick is made in the same cycle, using the new `ptr` and the current `req_valid`.
  - If a request is found, the FSM stays in GRANT with the new `out_sel`, giving back-to-back transfers.
  - If no request is found, the FSM goes to IDLE.
  - The channel just served has lowest priority in that pick.
- GRANT without a handshake:
  - `out_sel` is frozen.
  - No re-arbitration, even if a higher-priority request appears.
- Granted channel drops `req_valid` before its handshake (protocol violation by the producer):
  - The FSM goes to IDLE next cycle.
  - `ptr` is unchanged and no counter increments.
- Reset values: FSM IDLE, `ptr`=0, `out_sel`=0, `out_valid`=0, `req_ready`=0, `out_data`=`d0`, `grant_cnt`=0.

## Timing
- Request to `out_valid` latency from IDLE: 1 cycle.
- Sustained throughput with `out_ready`=1 and requests pending: 1 word per cycle.
- `out_sel` and `out_data` are stable while `out_valid && !out_ready`, provided producers hold their data.
- No combinational path from `req_valid` to `out_sel`. A combinational path exists from `out_ready` to `req_ready`.
- Reset mid-transfer:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight word is dropped, with no handshake reported.

## Configuration
- `ARB4_STATS_EN` defined:
  - Adds `grant_cnt`: four 8-bit counters.
  - Counter i increments on each handshake with `out_sel`=i.
  - Counters saturate at 255.
  - Counters clear only on reset.
- `ARB4_STATS_EN` undefined:
  - No `grant_cnt` port and no counter logic.
  - All other behaviour is identical.

## Structure
- Package `arb_pkg`:
  - State enum (`ARB_IDLE`, `ARB_GRANT`).
  - `ARB_N` = 4.
  - `ARB_SELW` = 2.
  - `ARB_CNTW` = 8.
- Sub-module `rr_pick4`: purely combinational.
  - Inputs: `req` (4 bits) and `ptr` (2 bits).
  - Outputs: `found` and `idx` (2 bits).
  - Reused in both IDLE and handshake re-pick.
- Datapath is one `mux4` instance driven by `out_sel`.

## Test plan
- Reset, all inputs active:
  - While `rst_n`=0: `out_valid`=0, `req_ready`=0000, `out_sel`=0.
  - After release: first grant goes to channel 0.
- Single request, `req_valid`=0100, `d2`=4'hA, `out_ready`=1:
  - Next cycle: `out_valid`=1, `out_sel`=2, `out_data`=4'hA, `req_ready`=0100.
  - Then IDLE, with `ptr`=3.
- `req_valid`=1111 held, `out_ready`=1: grants run 0,1,2,3,0,1, one handshake per cycle after the first.
- Backpressure:
  - Grant on channel 1 with `out_ready`=0 for 3 cycles; channel 0 raises a request meanwhile.
  - Required: `out_sel` stays 1 and `out_data` stays stable.
  - Then `out_ready`=1: handshake on channel 1, next grant goes to channel 0.
- Async reset:
  - Assert `rst_n`=0 mid-cycle during GRANT.
  - Required: `out_valid` and `req_ready` drop within the same cycle; the FSM restarts in IDLE with `ptr`=0.
- With `ARB4_STATS_EN`: 300 handshakes on channel 3 only → `grant_cnt[3]`=255, other counters 0.
